// File: rtl/fp_inst_sequencer.sv
// Program sequencer for the FP datapath: fetches imem words, issues them to data access
// and waits on the FPU for reads. Optional debug single-step is enabled by FP_SEQ_STEP_EN.
module fp_inst_sequencer #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
`ifdef FP_SEQ_STEP_EN
    input  logic            step_i,
`endif
    output logic [PC_W-1:0] imem_addr_o,
    output logic            imem_rd_o,
    input  logic [15:0]     imem_data_i,
    output logic [15:0]     inst_o,
    output logic            stop_o,
    output logic [127:0]    wr_data_o,
    input  logic            fpu_done_i,
    input  logic [63:0]     fpu_result_i,
    output logic            busy_o,
    output logic            halted_o,
    output logic            err_timeout_o,
    output logic [15:0]     retired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [PC_W-1:0] PcMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWaitFpu,
        StHalt,
        StError
`ifdef FP_SEQ_STEP_EN
        , StPause
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     result_q, result_d;
    logic [15:0]     retired_q, retired_d;
    logic            retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        retired_d = retired_q;
        retire    = 1'b0;

        case (state_q)
            StIdle, StHalt, StError: begin
                if (start_i) begin
                    state_d   = StFetch;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d    = imem_data_i;
                state_d = (imem_data_i == HALT_WORD) ? StHalt : StIssue;
            end
            StIssue: begin
                cnt_d = '0;
                if (ir_q[2]) begin
                    retire = 1'b1;
                end else begin
                    state_d = StWaitFpu;
                end
            end
            StWaitFpu: begin
                // A done arriving on the expiry cycle still retires the read.
                if (fpu_done_i) begin
                    result_d = fpu_result_i;
                    retire   = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef FP_SEQ_STEP_EN
            StPause: begin
                if (step_i) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (retire) begin
            retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
            // The last imem slot ends the program rather than wrapping to 0.
            if (pc_q == PcMax) begin
                state_d = StHalt;
            end else begin
                pc_d = pc_q + PC_W'(1);
`ifdef FP_SEQ_STEP_EN
                state_d = StPause;
`else
                state_d = StFetch;
`endif
            end
        end
    end

    always_comb begin
        imem_addr_o   = pc_q;
        imem_rd_o     = (state_q == StFetch);
        inst_o        = '0;
        stop_o        = 1'b1;
        if (state_q == StIssue || state_q == StWaitFpu) begin
            inst_o = ir_q;
            stop_o = 1'b0;
        end
        wr_data_o     = {result_q, 64'h0};
        busy_o        = !(state_q == StIdle || state_q == StHalt || state_q == StError);
        halted_o      = (state_q == StHalt);
        err_timeout_o = (state_q == StError);
        retired_o     = retired_q;
    end

endmodule

// File: tb/tb_fp_inst_sequencer.sv
// Directed bench for fp_inst_sequencer with PC_W=2 and TIMEOUT=8 and a
// synchronous-read imem model.
module tb_fp_inst_sequencer;

    localparam int unsigned PC_W    = 2;
    localparam int unsigned TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_data = 16'h0;
    logic [15:0]     inst;
    logic            stop;
    logic [127:0]    wr_data;
    logic            fpu_done = 1'b0;
    logic [63:0]     fpu_result = 64'h0;
    logic            busy;
    logic            halted;
    logic            err_timeout;
    logic [15:0]     retired;

    logic [15:0] mem [4];
    int vecs = 0;
    int errs = 0;

    localparam logic [63:0] R1 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] R2 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] R4 = 64'h0123_4567_89AB_CDEF;

    fp_inst_sequencer #(
        .PC_W     (PC_W),
        .TIMEOUT  (TIMEOUT),
        .HALT_WORD(16'hFFFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .imem_addr_o  (imem_addr),
        .imem_rd_o    (imem_rd),
        .imem_data_i  (imem_data),
        .inst_o       (inst),
        .stop_o       (stop),
        .wr_data_o    (wr_data),
        .fpu_done_i   (fpu_done),
        .fpu_result_i (fpu_result),
        .busy_o       (busy),
        .halted_o     (halted),
        .err_timeout_o(err_timeout),
        .retired_o    (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        mem[0] = 16'h0; mem[1] = 16'h0; mem[2] = 16'h0; mem[3] = 16'h0;
        #2;
        check("rst_stop", stop, 1);
        check("rst_inst", inst, 0);
        check("rst_rd", imem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err_timeout, 0);
        check("rst_retired", retired, 0);
        check("rst_wrdata", wr_data, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("idle_stop", stop, 1);

        // 1: single read then HALT_WORD
        mem[0] = 16'h0008; mem[1] = 16'hFFFF;
        pulse_start();
        check("t1_fetch_rd", imem_rd, 1);
        check("t1_fetch_addr", imem_addr, 0);
        check("t1_fetch_busy", busy, 1);
        tick(2);
        check("t1_issue_inst", inst, 16'h0008);
        check("t1_issue_stop", stop, 0);
        tick(1);
        check("t1_wait_inst", inst, 16'h0008);
        check("t1_wait_stop", stop, 0);
        tick(1);
        fpu_done = 1'b1; fpu_result = R1;
        tick(1);
        fpu_done = 1'b0;
        check("t1_retired", retired, 1);
        check("t1_next_addr", imem_addr, 1);
        check("t1_result", wr_data, {R1, 64'h0});
        tick(2);
        check("t1_halted", halted, 1);
        check("t1_halt_busy", busy, 0);
        check("t1_halt_stop", stop, 1);
        check("t1_halt_inst", inst, 0);
        check("t1_halt_retired", retired, 1);

        // 2: read then store of the fresh result
        mem[0] = 16'h0011; mem[1] = 16'h001C; mem[2] = 16'hFFFF;
        pulse_start();
        check("t2_halted_clr", halted, 0);
        check("t2_retired_clr", retired, 0);
        tick(2);
        check("t2_rd_inst", inst, 16'h0011);
        tick(1);
        fpu_done = 1'b1; fpu_result = R2;
        tick(1);
        fpu_done = 1'b0;
        tick(2);
        check("t2_st_inst", inst, 16'h001C);
        check("t2_st_stop", stop, 0);
        check("t2_st_wrdata", wr_data, {R2, 64'h0});
        tick(1);
        check("t2_st_retired", retired, 2);
        tick(2);
        check("t2_halted", halted, 1);
        check("t2_final_retired", retired, 2);

        // 3: FPU never answers
        mem[0] = 16'h0008; mem[1] = 16'hFFFF;
        pulse_start();
        tick(3);
        tick(TIMEOUT - 1);
        check("t3_last_wait_err", err_timeout, 0);
        check("t3_last_wait_busy", busy, 1);
        check("t3_last_wait_inst", inst, 16'h0008);
        tick(1);
        check("t3_err", err_timeout, 1);
        check("t3_err_stop", stop, 1);
        check("t3_err_busy", busy, 0);
        fpu_done = 1'b1; fpu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        tick(1);
        fpu_done = 1'b0;
        check("t3_err_sticky", err_timeout, 1);
        check("t3_stray_done", wr_data, {R2, 64'h0});

        // 4: done lands on the expiry cycle
        pulse_start();
        check("t4_err_clr", err_timeout, 0);
        check("t4_busy", busy, 1);
        tick(3);
        tick(TIMEOUT - 1);
        fpu_done = 1'b1; fpu_result = R4;
        tick(1);
        fpu_done = 1'b0;
        check("t4_no_err", err_timeout, 0);
        check("t4_retired", retired, 1);
        check("t4_result", wr_data, {R4, 64'h0});
        tick(2);
        check("t4_halted", halted, 1);
        check("t4_halt_err", err_timeout, 0);

        // 5: reset in WAIT_FPU
        pulse_start();
        tick(3);
        check("t5_wait_stop", stop, 0);
        rst = 1'b1;
        #1;
        check("t5_stop", stop, 1);
        check("t5_inst", inst, 0);
        check("t5_busy", busy, 0);
        check("t5_wrdata", wr_data, 0);
        check("t5_halted", halted, 0);
        check("t5_retired", retired, 0);
        check("t5_addr", imem_addr, 0);
        #1;
        rst = 1'b0;
        tick(1);
        check("t5_idle_busy", busy, 0);

        // 6: four stores, no HALT_WORD; stray start/done mid-program
        mem[0] = 16'h001C; mem[1] = 16'h001C; mem[2] = 16'h001C; mem[3] = 16'h001C;
        pulse_start();
        tick(5);
        start = 1'b1; fpu_done = 1'b1; fpu_result = 64'hFFFF_0000_FFFF_0000;
        tick(1);
        start = 1'b0; fpu_done = 1'b0;
        check("t6_retired2", retired, 2);
        check("t6_addr2", imem_addr, 2);
        tick(5);
        check("t6_last_addr", imem_addr, 3);
        check("t6_last_inst", inst, 16'h001C);
        check("t6_retired3", retired, 3);
        tick(1);
        check("t6_halted", halted, 1);
        check("t6_retired4", retired, 4);
        check("t6_nowrap", imem_addr, 3);
        check("t6_halt_rd", imem_rd, 0);
        check("t6_wrdata", wr_data, 0);
        tick(3);
        check("t6_still_halted", halted, 1);
        check("t6_still_retired", retired, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
